// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channel bundle used between the refill
// arbiter (master) and the AXI slave/interconnect (slave).
//   master: drives arid/araddr/arlen/arsize/arburst/arvalid and rready
//   slave : drives arready and rid/rdata/rresp/rlast/rvalid
interface cache_axi_rd_arbiter_if #(
  parameter int unsigned ID_WIDTH = 4
) ();
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read channel between the icache and dcache line-refill
// ports. Each grant issues one 4-beat INCR burst of 32-bit words and returns
// the assembled 128-bit line (word0 in [31:0]) on the granted cache's ret port.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   {i,d}cache_rd_req/addr     refill request and line address
//   {i,d}cache_rd_rdy          pulse when that cache's AR is accepted
//   {i,d}cache_ret_valid/data  one-cycle line return
//   rd_err                     with ret_valid: bad rresp or rlast misplacement
//   axi                        AXI read channels (master modport)
//
// Optional: define CACHE_AXI_RD_RR_ARB_EN for round-robin arbitration;
// default is fixed priority with dcache over icache.
module cache_axi_rd_arbiter #(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned ICACHE_ID = 0,
  parameter int unsigned DCACHE_ID = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   icache_rd_req,
  input  logic [31:0]            icache_rd_addr,
  output logic                   icache_rd_rdy,
  output logic                   icache_ret_valid,
  output logic [127:0]           icache_ret_data,
  input  logic                   dcache_rd_req,
  input  logic [31:0]            dcache_rd_addr,
  output logic                   dcache_rd_rdy,
  output logic                   dcache_ret_valid,
  output logic [127:0]           dcache_ret_data,
  output logic                   rd_err,
  cache_axi_rd_arbiter_if.master axi
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StRet} state_e;

  state_e              state_q, state_d;
  logic                gnt_dc_q, gnt_dc_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic [1:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic [127:0]        line_q, line_d;
  logic                pick_dc;

`ifdef CACHE_AXI_RD_RR_ARB_EN
  // Last-grant register: 1 = dcache was granted last.
  logic last_dc_q, last_dc_d;
  assign pick_dc = dcache_rd_req & (~icache_rd_req | ~last_dc_q);
`else
  assign pick_dc = dcache_rd_req;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_dc_d = gnt_dc_q;
    araddr_d = araddr_q;
    arid_d   = arid_q;
    beat_d   = beat_q;
    err_d    = err_q;
    line_d   = line_q;
`ifdef CACHE_AXI_RD_RR_ARB_EN
    last_dc_d = last_dc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (icache_rd_req || dcache_rd_req) begin
          gnt_dc_d = pick_dc;
          araddr_d = pick_dc ? {dcache_rd_addr[31:4], 4'b0} : {icache_rd_addr[31:4], 4'b0};
          arid_d   = pick_dc ? ID_WIDTH'(DCACHE_ID) : ID_WIDTH'(ICACHE_ID);
          state_d  = StAr;
`ifdef CACHE_AXI_RD_RR_ARB_EN
          last_dc_d = pick_dc;
`endif
        end
      end
      StAr: begin
        if (axi.arready) state_d = StR;
      end
      StR: begin
        if (axi.rvalid) begin
          line_d[{beat_q, 5'b0} +: 32] = axi.rdata;
          // rlast must appear exactly on the fourth beat.
          if (axi.rresp != 2'b00 || (axi.rlast != (beat_q == 2'd3))) err_d = 1'b1;
          beat_d = beat_q + 2'd1;
          // Fourth beat closes the burst whatever rlast says.
          if (beat_q == 2'd3) state_d = StRet;
        end
      end
      StRet: begin
        err_d   = 1'b0;
        beat_d  = 2'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_dc_q <= 1'b0;
      araddr_q <= '0;
      arid_q   <= '0;
      beat_q   <= 2'd0;
      err_q    <= 1'b0;
      line_q   <= '0;
`ifdef CACHE_AXI_RD_RR_ARB_EN
      last_dc_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_dc_q <= gnt_dc_d;
      araddr_q <= araddr_d;
      arid_q   <= arid_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      line_q   <= line_d;
`ifdef CACHE_AXI_RD_RR_ARB_EN
      last_dc_q <= last_dc_d;
`endif
    end
  end

  assign axi.arvalid = (state_q == StAr);
  assign axi.araddr  = araddr_q;
  assign axi.arid    = arid_q;
  assign axi.arlen   = 8'd3;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.rready  = (state_q == StR);

  assign icache_rd_rdy    = (state_q == StAr) & axi.arready & ~gnt_dc_q;
  assign dcache_rd_rdy    = (state_q == StAr) & axi.arready & gnt_dc_q;
  assign icache_ret_valid = (state_q == StRet) & ~gnt_dc_q;
  assign dcache_ret_valid = (state_q == StRet) & gnt_dc_q;
  assign rd_err           = (state_q == StRet) & err_q;

  // Both ports see the same line register; it is only meaningful with ret_valid.
  assign icache_ret_data = line_q;
  assign dcache_ret_data = line_q;

  // rid is deliberately not checked; line offsets are dropped.
  logic unused_bits;
  assign unused_bits = ^{axi.rid, icache_rd_addr[3:0], dcache_rd_addr[3:0]};

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
module tb_cache_axi_rd_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_rd_req, dcache_rd_req;
  logic [31:0]  icache_rd_addr, dcache_rd_addr;
  logic         icache_rd_rdy, dcache_rd_rdy;
  logic         icache_ret_valid, dcache_ret_valid;
  logic [127:0] icache_ret_data, dcache_ret_data;
  logic         rd_err;

  cache_axi_rd_arbiter_if #(.ID_WIDTH(4)) axi ();

  cache_axi_rd_arbiter #(
    .ID_WIDTH (4),
    .ICACHE_ID(0),
    .DCACHE_ID(1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .icache_rd_req   (icache_rd_req),
    .icache_rd_addr  (icache_rd_addr),
    .icache_rd_rdy   (icache_rd_rdy),
    .icache_ret_valid(icache_ret_valid),
    .icache_ret_data (icache_ret_data),
    .dcache_rd_req   (dcache_rd_req),
    .dcache_rd_addr  (dcache_rd_addr),
    .dcache_rd_rdy   (dcache_rd_rdy),
    .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_data (dcache_ret_data),
    .rd_err          (rd_err),
    .axi             (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ic_ret_cnt = 0, dc_ret_cnt = 0;
  int exp_ic_cnt = 0, exp_dc_cnt = 0;
  bit exp_last_dc;

  logic [31:0] bdata[4];
  int          bgap[4];
  logic [1:0]  bresp[4];
  logic        blast[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (icache_ret_valid) ic_ret_cnt <= ic_ret_cnt + 1;
    if (dcache_ret_valid) dc_ret_cnt <= dc_ret_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      bdata[i] = base + 32'(i);
      bgap[i]  = 0;
      bresp[i] = 2'b00;
      blast[i] = (i == 3);
    end
  endtask

  // Expected tie winner, derived from the arbitration rules.
  function automatic bit tie_winner_dc();
`ifdef CACHE_AXI_RD_RR_ARB_EN
    return !exp_last_dc;
`else
    return 1'b1;
`endif
  endfunction

  // Entered in the IDLE cycle where the request is visible.
  task automatic do_ar(input bit is_dc, input logic [31:0] exp_addr, input int delay,
                       output int rdy_cyc);
    logic [3:0] exp_id;
    exp_id = is_dc ? 4'd1 : 4'd0;
    axi.arready = 1'b0;
    @(negedge clk);
    check_eq("idle_arvalid", axi.arvalid, 0);
    tick();
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_eq("wait_arvalid", axi.arvalid, 1);
      check_eq("wait_araddr", axi.araddr, exp_addr);
      check_eq("wait_arid", axi.arid, exp_id);
      check_eq("wait_rdy", {icache_rd_rdy, dcache_rd_rdy}, 0);
      tick();
    end
    axi.arready = 1'b1;
    @(negedge clk);
    rdy_cyc = cyc;
    check_eq("arvalid", axi.arvalid, 1);
    check_eq("araddr", axi.araddr, exp_addr);
    check_eq("arid", axi.arid, exp_id);
    check_eq("arlen", axi.arlen, 8'd3);
    check_eq("arsize", axi.arsize, 3'b010);
    check_eq("arburst", axi.arburst, 2'b01);
    check_eq("icache_rd_rdy", icache_rd_rdy, !is_dc);
    check_eq("dcache_rd_rdy", dcache_rd_rdy, is_dc);
    tick();
    axi.arready = 1'b0;
    if (is_dc) dcache_rd_req = 1'b0;
    else       icache_rd_req = 1'b0;
    exp_last_dc = is_dc;
  endtask

  task automatic do_r(input bit is_dc, input logic exp_err, output int ret_cyc);
    logic [127:0] exp_line;
    for (int i = 0; i < 4; i++) exp_line[i*32 +: 32] = bdata[i];
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < bgap[i]; g++) begin
        axi.rvalid = 1'b0;
        @(negedge clk);
        check_eq("gap_no_ret", {icache_ret_valid, dcache_ret_valid}, 0);
        tick();
      end
      axi.rvalid = 1'b1;
      axi.rdata  = bdata[i];
      axi.rresp  = bresp[i];
      axi.rlast  = blast[i];
      axi.rid    = 4'($urandom);
      @(negedge clk);
      check_eq("rready", axi.rready, 1);
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    @(negedge clk);
    ret_cyc = cyc;
    check_eq("icache_ret_valid", icache_ret_valid, !is_dc);
    check_eq("dcache_ret_valid", dcache_ret_valid, is_dc);
    check_eq("ret_data", is_dc ? dcache_ret_data : icache_ret_data, exp_line);
    check_eq("rd_err", rd_err, exp_err);
    if (is_dc) exp_dc_cnt++;
    else       exp_ic_cnt++;
    tick();
  endtask

  task automatic run_single(input bit is_dc, input logic [31:0] addr, input int delay,
                            input logic exp_err);
    int rc, tc;
    if (is_dc) begin dcache_rd_req = 1'b1; dcache_rd_addr = addr; end
    else       begin icache_rd_req = 1'b1; icache_rd_addr = addr; end
    do_ar(is_dc, {addr[31:4], 4'b0}, delay, rc);
    do_r(is_dc, exp_err, tc);
  endtask

  task automatic run_tie(input logic [31:0] ic_addr, input logic [31:0] dc_addr);
    bit w;
    int rc, tc;
    icache_rd_req = 1'b1; icache_rd_addr = ic_addr;
    dcache_rd_req = 1'b1; dcache_rd_addr = dc_addr;
    w = tie_winner_dc();
    do_ar(w, w ? {dc_addr[31:4], 4'b0} : {ic_addr[31:4], 4'b0}, 0, rc);
    set_beats(w ? 32'hD000_0000 : 32'hC000_0000);
    do_r(w, 1'b0, tc);
    // Loser still requesting; granted from the IDLE cycle after RET.
    do_ar(!w, w ? {ic_addr[31:4], 4'b0} : {dc_addr[31:4], 4'b0}, 0, rc);
    set_beats(w ? 32'hC100_0000 : 32'hD100_0000);
    do_r(!w, 1'b0, tc);
  endtask

  initial begin
    int c0, rc, tc, dc_before;
    reset = 1'b1;
    icache_rd_req = 1'b0; icache_rd_addr = '0;
    dcache_rd_req = 1'b0; dcache_rd_addr = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    exp_last_dc = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_arvalid", axi.arvalid, 0);
    check_eq("rst_rready", axi.rready, 0);
    check_eq("rst_rd_rdy", {icache_rd_rdy, dcache_rd_rdy}, 0);
    check_eq("rst_ret_valid", {icache_ret_valid, dcache_ret_valid}, 0);
    check_eq("rst_rd_err", rd_err, 0);
    check_eq("rst_ic_ret_data", icache_ret_data, 0);
    check_eq("rst_dc_ret_data", dcache_ret_data, 0);
    check_eq("rst_araddr", axi.araddr, 0);
    tick();

    // First tie straight after reset.
    run_tie(32'h0000_0100, 32'h0000_0200);

    // Single icache refill, minimum latency.
    icache_rd_req = 1'b1; icache_rd_addr = 32'h1FC0_0014;
    bdata[0] = 32'h11; bdata[1] = 32'h22; bdata[2] = 32'h33; bdata[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin bgap[i] = 0; bresp[i] = 2'b00; blast[i] = (i == 3); end
    c0 = cyc;
    do_ar(1'b0, 32'h1FC0_0010, 0, rc);
    check_eq("lat_rd_rdy", 32'(rc - c0), 1);
    do_r(1'b0, 1'b0, tc);
    check_eq("lat_ret_valid", 32'(tc - c0), 6);
    check_eq("ic_line_lit", icache_ret_data,
             128'h00000044_00000033_00000022_00000011);

    // Second tie.
    run_tie(32'h1000_0104, 32'h2000_020C);

    // arready held low for 5 cycles.
    set_beats(32'hA5A5_0000);
    run_single(1'b1, 32'h8000_003C, 5, 1'b0);

    // rvalid gaps: beats at +0, +3, +4, +9.
    set_beats(32'h5EED_0010);
    bgap[1] = 2; bgap[3] = 4;
    run_single(1'b0, 32'h0000_0040, 0, 1'b0);

    // rresp error on beat 2.
    set_beats(32'hBAD0_0000);
    bresp[1] = 2'b10;
    run_single(1'b1, 32'h0000_0080, 0, 1'b1);

    // Early rlast on beat 3.
    set_beats(32'hBAD1_0000);
    blast[2] = 1'b1;
    run_single(1'b0, 32'h0000_00C0, 0, 1'b1);

    // Reset during beat 2 of a dcache burst.
    dc_before = dc_ret_cnt;
    dcache_rd_req = 1'b1; dcache_rd_addr = 32'h0000_0300;
    do_ar(1'b1, 32'h0000_0300, 0, rc);
    axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_0000; axi.rlast = 1'b0;
    tick();
    axi.rdata = 32'hDEAD_0001; reset = 1'b1;
    tick();
    reset = 1'b0; axi.rvalid = 1'b0;
    exp_last_dc = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rready", axi.rready, 0);
    check_eq("mid_rst_arvalid", axi.arvalid, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("mid_rst_no_ret", dcache_ret_valid, 0);
      tick();
    end
    check_eq("mid_rst_dc_cnt", dc_ret_cnt, dc_before);

    // Normal icache refill after reset.
    set_beats(32'h600D_0000);
    run_single(1'b0, 32'h0000_0500, 0, 1'b0);

    tick(); tick();
    check_eq("ic_ret_count", ic_ret_cnt, exp_ic_cnt);
    check_eq("dc_ret_count", dc_ret_cnt, exp_dc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
